// File: rtl/ex_div_unit_if.sv
// Handshake and operand bundle between the ID/EX register and the EX-stage divider.
interface ex_div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start_i;
    logic                  kill_i;
    logic [1:0]            op_i;
    logic [DATA_WIDTH-1:0] rs1_i;
    logic [DATA_WIDTH-1:0] rs2_i;
    logic                  stall_o;
    logic                  busy_o;
    logic                  done_o;
    logic [DATA_WIDTH-1:0] result_o;

    // Pipeline side: issues the divide and consumes the result/stall.
    modport master (
        output start_i, kill_i, op_i, rs1_i, rs2_i,
        input  stall_o, busy_o, done_o, result_o
    );

    // Divider side.
    modport slave (
        input  start_i, kill_i, op_i, rs1_i, rs2_i,
        output stall_o, busy_o, done_o, result_o
    );
endinterface

// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Works on operand magnitudes and applies sign correction when the last step
// retires; divide-by-zero and signed overflow bypass the iteration entirely.
module ex_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    ex_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [DATA_WIDTH-1:0] INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] quo_q, rem_q, dvs_q, result_q;
    logic                  is_rem_q, neg_quo_q, neg_rem_q;

    // Accept-time decode of the incoming operands.
    logic                  accept, is_signed, a_neg, b_neg, div_zero, overflow;
    logic [DATA_WIDTH-1:0] abs_a, abs_b;

    assign accept    = (state_q == IDLE) && bus.start_i && !bus.kill_i;
    assign is_signed = !bus.op_i[0];
    assign a_neg     = is_signed && bus.rs1_i[DATA_WIDTH-1];
    assign b_neg     = is_signed && bus.rs2_i[DATA_WIDTH-1];
    assign abs_a     = a_neg ? -bus.rs1_i : bus.rs1_i;
    assign abs_b     = b_neg ? -bus.rs2_i : bus.rs2_i;
    assign div_zero  = (bus.rs2_i == '0);
    assign overflow  = is_signed && (bus.rs1_i == INT_MIN) && (bus.rs2_i == '1);

    // One restoring step. rem_q < dvs_q always holds, so the shifted partial
    // remainder needs DATA_WIDTH+1 bits; its MSB alone forces a subtraction and
    // the difference then still fits in DATA_WIDTH bits.
    logic [DATA_WIDTH-1:0] rem_shift, rem_next, quo_next, quo_fin, rem_fin;
    logic                  step_ge;

    assign rem_shift = {rem_q[DATA_WIDTH-2:0], quo_q[DATA_WIDTH-1]};
    assign step_ge   = rem_q[DATA_WIDTH-1] || (rem_shift >= dvs_q);
    assign rem_next  = step_ge ? (rem_shift - dvs_q) : rem_shift;
    assign quo_next  = {quo_q[DATA_WIDTH-2:0], step_ge};
    assign quo_fin   = neg_quo_q ? -quo_next : quo_next;
    assign rem_fin   = neg_rem_q ? -rem_next : rem_next;

    // State register.
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a flush overrides everything and returns to IDLE.
    // NOTE: state_d is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (div_zero || overflow) ? DONE : CALC;
            CALC: if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.kill_i) state_d = IDLE;
    end

    // Outputs: stall covers the accept cycle and the whole iteration, not DONE,
    // so the pipeline advances as the result is captured downstream.
    always_comb begin
        bus.busy_o   = (state_q != IDLE);
        bus.done_o   = (state_q == DONE);
        bus.stall_o  = accept || (state_q == CALC);
        bus.result_o = result_q;
    end

    // Datapath: latch magnitudes at accept, iterate in CALC, register the result.
    // NOTE: the iteration registers are reset along with the control state so
    // no X can leak into result_o, even though control alone would mask them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (!bus.kill_i) begin
            case (state_q)
                IDLE: if (accept) begin
                    is_rem_q  <= bus.op_i[1];
                    neg_quo_q <= a_neg ^ b_neg;
                    neg_rem_q <= a_neg;
                    quo_q     <= abs_a;
                    rem_q     <= '0;
                    dvs_q     <= abs_b;
                    cnt_q     <= CNT_W'(DATA_WIDTH);
                    if (div_zero)      result_q <= bus.op_i[1] ? bus.rs1_i : '1;
                    else if (overflow) result_q <= bus.op_i[1] ? '0 : INT_MIN;
                end
                CALC: begin
                    quo_q <= quo_next;
                    rem_q <= rem_next;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) result_q <= is_rem_q ? rem_fin : quo_fin;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: directed RV32M corner cases, flush and
// reset scenarios, then randomized operations against an arithmetic model.
module tb_ex_div_unit;
    localparam int W = 32;
    localparam logic [W-1:0] INT_MIN = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fails = 0;

    ex_div_unit_if #(.DATA_WIDTH(W)) bus ();

    ex_div_unit #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics using native signed/unsigned arithmetic.
    function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 0) return op[1] ? a : '1;
        if (!op[0]) begin
            if (a == INT_MIN && b == '1) return op[1] ? '0 : INT_MIN;
            return op[1] ? W'(sa % sb) : W'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
        if (b == 0 || (!op[0] && a == INT_MIN && b == '1)) return 1;
        return W + 1;
    endfunction

    // Issue one operation and follow it to completion, holding start_i high as
    // a stalled pipeline would and scrambling operands once accepted.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        logic [W-1:0] exp;
        int           cyc;
        bit           got_done;
        bit           stall_ok;
        exp = ref_result(op, a, b);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.rs1_i   = a;
        bus.rs2_i   = b;
        #1;
        check({tag, "/stall_accept"}, W'(bus.stall_o), W'(1));
        cyc = 0;
        got_done = 0;
        stall_ok = 1;
        while (cyc < 40 && !got_done) begin
            @(negedge clk);
            cyc++;
            if (bus.done_o) got_done = 1;
            else begin
                if (!bus.stall_o || !bus.busy_o) stall_ok = 0;
                bus.op_i  = 2'($urandom);
                bus.rs1_i = $urandom;
                bus.rs2_i = $urandom;
            end
        end
        check({tag, "/latency"}, W'(cyc), W'(ref_latency(op, a, b)));
        check({tag, "/result"}, bus.result_o, exp);
        check({tag, "/stall_in_done"}, W'(bus.stall_o), W'(0));
        check({tag, "/stall_while_busy"}, W'(stall_ok), W'(1));
        @(negedge clk);
        check({tag, "/done_one_cycle"}, W'(bus.done_o), W'(0));
        check({tag, "/result_held"}, bus.result_o, exp);
        bus.start_i = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return INT_MIN;
            2: return '1;
            3: return W'($urandom_range(0, 20));
            4: return -W'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [W-1:0] prev;
        bit           saw_done;
        bus.start_i = 1'b0;
        bus.kill_i  = 1'b0;
        bus.op_i    = 2'b00;
        bus.rs1_i   = '0;
        bus.rs2_i   = '0;

        repeat (2) @(negedge clk);
        check("reset/busy", W'(bus.busy_o), W'(0));
        check("reset/done", W'(bus.done_o), W'(0));
        check("reset/stall", W'(bus.stall_o), W'(0));
        check("reset/result", bus.result_o, '0);
        rst_n = 1'b1;

        // Directed cases.
        do_op("divu_100_7", 2'b01, 32'd100, 32'd7);
        do_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2);
        do_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2);
        do_op("remu_m7_2",  2'b11, 32'hFFFF_FFF9, 32'd2);
        do_op("div_5_0",    2'b00, 32'd5, 32'd0);
        do_op("rem_5_0",    2'b10, 32'd5, 32'd0);
        do_op("div_ovf",    2'b00, INT_MIN, 32'hFFFF_FFFF);
        do_op("rem_ovf",    2'b10, INT_MIN, 32'hFFFF_FFFF);
        do_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1);
        do_op("divu_big",   2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFF);

        // Flush at cycle 10 of a DIVU: no done pulse, result untouched.
        prev = bus.result_o;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 2'b01;
        bus.rs1_i   = 32'hFFFF_FFFF;
        bus.rs2_i   = 32'd3;
        saw_done = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.done_o) saw_done = 1;
        end
        bus.kill_i = 1'b1;
        @(negedge clk);
        check("kill/busy", W'(bus.busy_o), W'(0));
        check("kill/done", W'(bus.done_o), W'(0));
        check("kill/result", bus.result_o, prev);
        bus.kill_i  = 1'b0;
        bus.start_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done_o) saw_done = 1;
        end
        check("kill/no_done_pulse", W'(saw_done), W'(0));

        // start_i and kill_i together in IDLE: not accepted.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.kill_i  = 1'b1;
        bus.op_i    = 2'b01;
        bus.rs1_i   = 32'd50;
        bus.rs2_i   = 32'd5;
        #1;
        check("start_kill/stall", W'(bus.stall_o), W'(0));
        @(negedge clk);
        check("start_kill/busy", W'(bus.busy_o), W'(0));
        bus.start_i = 1'b0;
        bus.kill_i  = 1'b0;
        do_op("divu_9_3", 2'b01, 32'd9, 32'd3);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 2'b01;
        bus.rs1_i   = 32'd12345;
        bus.rs2_i   = 32'd7;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        #1;
        check("rst_mid/busy", W'(bus.busy_o), W'(0));
        check("rst_mid/stall", W'(bus.stall_o), W'(0));
        check("rst_mid/done", W'(bus.done_o), W'(0));
        check("rst_mid/result", bus.result_o, '0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("divu_1000_10", 2'b01, 32'd1000, 32'd10);

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            do_op($sformatf("rand%0d", i), 2'($urandom), rand_operand(), rand_operand());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
